// File: rtl/adder_tree_acc.sv
// Registered pairwise adder tree reducing OUTPUT_SIZE signed 32-bit lanes to
// one sum, followed by an accumulator that merges multi-beat groups.
module adder_tree_acc #(
  parameter int OUTPUT_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [OUTPUT_SIZE*32-1:0]     adder_in,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic signed [31:0]            sum_out,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int DATA_W = 32;
  localparam int LEVELS = $clog2(OUTPUT_SIZE);

  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N = OUTPUT_SIZE >> (k + 1);

    logic signed [DATA_W-1:0] prev [2*N];
    logic                     prev_vld;
    logic                     prev_last;
    logic signed [DATA_W-1:0] sum_p [N];
    logic                     vld_p;
    logic                     last_p;

    if (k == 0) begin : g_in
      for (genvar j = 0; j < 2*N; j++) begin : g_lane
        assign prev[j] = adder_in[j*DATA_W +: DATA_W];
      end
      assign prev_vld  = in_valid;
      assign prev_last = in_last;
    end else begin : g_up
      for (genvar j = 0; j < 2*N; j++) begin : g_node
        assign prev[j] = g_lvl[k-1].sum_p[j];
      end
      assign prev_vld  = g_lvl[k-1].vld_p;
      assign prev_last = g_lvl[k-1].last_p;
    end

    // tree stage k: data carries no reset, bubbles are flagged by vld_p
    always_ff @(posedge clk) begin
      if (en) begin
        for (int j = 0; j < N; j++) begin
          sum_p[j] <= wrap_add(prev[2*j], prev[2*j+1]);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p  <= 1'b0;
        last_p <= 1'b0;
      end else if (en) begin
        vld_p  <= prev_vld;
        last_p <= prev_last;
      end
    end
  end

  logic signed [DATA_W-1:0] tree_sum;
  logic                     tree_vld;
  logic                     tree_last;
  logic signed [DATA_W-1:0] acc;
  logic                     in_grp;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] total;

  assign tree_sum  = g_lvl[LEVELS-1].sum_p[0];
  assign tree_vld  = g_lvl[LEVELS-1].vld_p;
  assign tree_last = g_lvl[LEVELS-1].last_p;
  assign base      = in_grp ? acc : '0;
  assign total     = wrap_add(base, tree_sum);

  // accumulator stage: closing a group loads sum_out; consume and load may share an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      in_grp    <= 1'b0;
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (tree_vld) begin
        if (tree_last) begin
          sum_out   <= total;
          out_valid <= 1'b1;
          in_grp    <= 1'b0;
          acc       <= '0;
        end else begin
          acc       <= total;
          in_grp    <= 1'b1;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
